div_rr_scheduler: RTL and testbench
===================================

// Module: div_rr_scheduler
// PURPOSE
// - Shares one sequential divider (start/busy/valid/ovf/dvz handshake) among N_REQ requesters.
// - Arbitrates round-robin and captures the winner's dividend/divisor.
// - Issues a one-cycle start to the divider and waits for its one-cycle completion pulse.
// - Returns quotient and status to the winner on a one-cycle done strobe.
// - Sits between the requesting units and the divider controller/datapath pair.
// PARAMETERS
// - N_REQ   4   number of requesters, >=2
// - DW      10  dividend/divisor/quotient width
// - TMO_CYC 64  watchdog limit in WAIT cycles; used only with DIV_SCHED_TIMEOUT_EN
// PORTS
// - clk         in   1         single clock, rising edge
// - sclr_n      in   1         reset: synchronous, active-low
// - req         in   N_REQ     per-requester request level
// - req_a       in   N_REQ*DW  packed dividends; slice i belongs to req[i]
// - req_b       in   N_REQ*DW  packed divisors; slice i belongs to req[i]
// - gnt         out  N_REQ     one-hot, one-cycle pulse when operands are captured
// - done        out  N_REQ     one-hot, one-cycle pulse when the response is valid
// - rsp_q       out  DW        quotient; valid while done is high
// - rsp_status  out  2         00 OK, 01 OVF, 10 DVZ, 11 TMO
// - sched_busy  out  1         high in every state except IDLE
// - div_start   out  1         divider start pulse
// - div_sclr    out  1         divider sync clear, active-high
// - div_a       out  DW        captured dividend
// - div_b       out  DW        captured divisor
// - div_valid   in   1         divider done, no overflow
// - div_ovf     in   1         divider done, overflow
// - div_dvz     in   1         divider done, divide-by-zero
// - div_q       in   DW        divider quotient
// BEHAVIOUR
// - Reset (clk edge with sclr_n=0): state=IDLE; rr_ptr=N_REQ-1 so req[0] wins first.
//   - gnt, done, div_start, div_a, div_b, rsp_q, rsp_status, sched_busy all reset to 0.
//   - div_sclr = ~sclr_n | tmo_pulse, so the divider is cleared together with this block.
// - FSM states: IDLE, ISSUE, WAIT, RESP.
// - IDLE: if |req, pick the first set bit searching from rr_ptr+1 with wrap (N_REQ-1 -> 0).
//   - On that edge: idx<=winner, div_a/div_b<=winner's slices, gnt[winner]=1 for one cycle, go to ISSUE.
// - ISSUE: div_start=1 for exactly one cycle -> WAIT.
// - WAIT: sample the completion pulses; priority on coincidence is dvz > ovf > valid.
//   - On completion: rsp_status is set, rsp_q<=div_q (0 for DVZ), go to RESP. Otherwise stay in WAIT.
// - RESP: done[idx]=1 for one cycle; rr_ptr<=idx -> IDLE.
// - Overhead latency: req seen to start = 2 edges; completion to done = 1 edge.
// - Back-to-back: a req held in IDLE after RESP is granted on the next edge, so there is no starvation.
// - Requesters may drop req after gnt. The operation still completes and done is still pulsed.
// - A req rising during ISSUE, WAIT or RESP waits for IDLE. Only one operation is in flight.
// - Completion pulses outside WAIT are ignored.
// - Mid-operation reset: the FSM aborts to IDLE and no done is issued for the lost operation.
// CONFIGURATION
// - Optional feature macro: DIV_SCHED_TIMEOUT_EN.
// - Defined:
//   - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
//   - When it reaches TMO_CYC-1 with no completion, tmo_pulse=1 for one cycle (div_sclr high).
//   - rsp_status=11, rsp_q=0, go to RESP.
//   - A completion pulse in the same cycle as expiry wins over the timeout.
// - Undefined: no counter; div_sclr=~sclr_n; WAIT is unbounded; status 11 is never produced.
// STRUCTURE
// - Package div_sched_pkg holds:
//   - state enum: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
//   - status constants: ST_OK, ST_OVF, ST_DVZ, ST_TMO
// - Sub-module rr_pick (combinational): inputs req and rr_ptr; outputs one-hot winner and its index.
// - Top level: FSM, operand/response registers, optional watchdog.
// TESTING
// - Single requester: req=4'b0001, a=100, b=7, divider model returns valid q=14 -> gnt[0], div_start 2 edges after req, done[0], q=14, status 00.
// - Fairness: req=4'b1111 held for 8 ops -> grant order 0,1,2,3,0,1,2,3; each done matches its own a/b.
// - Divide-by-zero and overflow: b=0 -> model dvz -> status 10, q=0; model ovf -> status 01; dvz+ovf in the same cycle -> status 10.
// - Mid-operation reset: sclr_n=0 during WAIT -> all outputs 0, div_sclr=1, no done; after release req[2] is granted first only if req[0..1]=0.
// - Timeout (macro on, TMO_CYC=8): model never completes -> div_sclr pulse 8 cycles after entering WAIT, done with status 11; macro off -> WAIT persists 100 cycles.
// - Late and dropped req: req[1] rises during WAIT -> granted on the first IDLE edge; req[0] dropped after gnt -> done[0] still pulses.

Source files
------------

// File: rtl/div_rr_scheduler_pkg.sv
// Shared types for the divider round-robin scheduler.
//   state_t   : scheduler FSM encoding
//   status_t  : response status code returned with done
//   cpl_status: maps coincident divider completion flags to a status
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK  = 2'b00;
  localparam status_t ST_OVF = 2'b01;
  localparam status_t ST_DVZ = 2'b10;
  localparam status_t ST_TMO = 2'b11;

  // Divide-by-zero outranks overflow, which outranks a clean result.
  function automatic status_t cpl_status(input logic dvz, input logic ovf);
    if (dvz) return ST_DVZ;
    if (ovf) return ST_OVF;
    return ST_OK;
  endfunction

endpackage

// File: rtl/div_rr_scheduler_if.sv
// Bus bundle between requesters, the scheduler and the shared divider.
//   Requester side : req, req_a, req_b -> gnt, done, rsp_q, rsp_status
//   Divider side   : div_start, div_sclr, div_a, div_b -> div_valid, div_ovf, div_dvz, div_q
//   master modport : the scheduler; slave modport : requesters + divider
interface div_rr_scheduler_if
  import div_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 10
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [DW-1:0]       rsp_q;
  status_t             rsp_status;

  logic                div_start;
  logic                div_sclr;
  logic [DW-1:0]       div_a;
  logic [DW-1:0]       div_b;
  logic                div_valid;
  logic                div_ovf;
  logic                div_dvz;
  logic [DW-1:0]       div_q;

  modport master (
    input  req, req_a, req_b, div_valid, div_ovf, div_dvz, div_q,
    output gnt, done, rsp_q, rsp_status, div_start, div_sclr, div_a, div_b
  );

  modport slave (
    output req, req_a, req_b, div_valid, div_ovf, div_dvz, div_q,
    input  gnt, done, rsp_q, rsp_status, div_start, div_sclr, div_a, div_b
  );

endinterface

// File: rtl/div_rr_scheduler_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   rr_ptr  : index of the last served requester
//   win_oh  : one-hot winner (zero when no request)
//   win_idx : winner index, searched from rr_ptr+1 with wrap
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx
);

  // Scan farthest-first so the nearest set bit after rr_ptr is the last write.
  always_comb begin
    int unsigned j;
    j       = 0;
    win_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (32'(rr_ptr) + 32'(k)) % N_REQ;
      if (req[IW'(j)]) win_idx = IW'(j);
    end
    win_oh = (|req) ? (N_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/div_rr_scheduler.sv
// Round-robin scheduler sharing one sequential divider among N_REQ requesters.
//   clk, sclr_n : clock and synchronous active-low reset
//   bus         : requester and divider handshake bundle (master side)
//   sched_busy  : high whenever the scheduler is not IDLE
// Optional watchdog: define DIV_SCHED_TIMEOUT_EN to abort WAIT after TMO_CYC cycles.
module div_rr_scheduler
  import div_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = 10,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic               clk,
  input  logic               sclr_n,
  div_rr_scheduler_if.master bus,
  output logic               sched_busy
);

  localparam int unsigned IW = $clog2(N_REQ);

  state_t           state, state_nx;
  logic [IW-1:0]    idx, idx_nx, rr_ptr, rr_ptr_nx, win_idx;
  logic [N_REQ-1:0] win_oh, gnt_nx, done_nx;
  logic [DW-1:0]    a_nx, b_nx, q_nx;
  status_t          status_nx;
  logic             start_nx, any_req, cpl, tmo_pulse;

  assign any_req = |bus.req;
  assign cpl     = bus.div_valid | bus.div_ovf | bus.div_dvz;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO_CYC) + 1;
  logic [CW-1:0] wd_cnt;

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!sclr_n || state != WAIT) wd_cnt <= '0;
    else                          wd_cnt <= wd_cnt + CW'(1);
  end

  // A completion in the expiry cycle takes precedence over the timeout.
  assign tmo_pulse = (state == WAIT) && !cpl && (wd_cnt == CW'(TMO_CYC - 1));
`else
  logic tmo_cyc_unused;
  assign tmo_cyc_unused = (TMO_CYC == 0);
  assign tmo_pulse      = 1'b0;
`endif

  // Divider is cleared alongside this block and on a watchdog abort.
  assign bus.div_sclr = ~sclr_n | tmo_pulse;

  // State register.
  always_ff @(posedge clk) begin
    if (!sclr_n) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cpl || tmo_pulse) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    gnt_nx    = '0;
    done_nx   = '0;
    start_nx  = 1'b0;
    idx_nx    = idx;
    rr_ptr_nx = rr_ptr;
    a_nx      = bus.div_a;
    b_nx      = bus.div_b;
    q_nx      = bus.rsp_q;
    status_nx = bus.rsp_status;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nx = win_oh;
          idx_nx = win_idx;
          a_nx   = bus.req_a[int'(win_idx)*DW +: DW];
          b_nx   = bus.req_b[int'(win_idx)*DW +: DW];
        end
      end
      ISSUE: start_nx = 1'b1;
      WAIT: begin
        if (cpl) begin
          status_nx = cpl_status(bus.div_dvz, bus.div_ovf);
          q_nx      = bus.div_dvz ? '0 : bus.div_q;
          done_nx   = N_REQ'(1) << idx;
        end else if (tmo_pulse) begin
          status_nx = ST_TMO;
          q_nx      = '0;
          done_nx   = N_REQ'(1) << idx;
        end
      end
      RESP:    rr_ptr_nx = idx;
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      idx            <= '0;
      rr_ptr         <= IW'(N_REQ - 1);
      bus.gnt        <= '0;
      bus.done       <= '0;
      bus.div_start  <= 1'b0;
      bus.div_a      <= '0;
      bus.div_b      <= '0;
      bus.rsp_q      <= '0;
      bus.rsp_status <= ST_OK;
      sched_busy     <= 1'b0;
    end else begin
      idx            <= idx_nx;
      rr_ptr         <= rr_ptr_nx;
      bus.gnt        <= gnt_nx;
      bus.done       <= done_nx;
      bus.div_start  <= start_nx;
      bus.div_a      <= a_nx;
      bus.div_b      <= b_nx;
      bus.rsp_q      <= q_nx;
      bus.rsp_status <= status_nx;
      sched_busy     <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Randomized self-checking bench for div_rr_scheduler with a behavioural
// round-robin / divider reference model. Honours DIV_SCHED_TIMEOUT_EN.
module tb_div_rr_scheduler;
  import div_sched_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 10;
  localparam int unsigned TMO = 8;

  localparam int M_AUTO  = 0;
  localparam int M_OVF   = 1;
  localparam int M_BOTH  = 2;
  localparam int M_NEVER = 3;

  logic clk = 1'b0;
  logic sclr_n;
  logic sched_busy;

  always #5 clk = ~clk;

  div_rr_scheduler_if #(.N_REQ(N), .DW(DW)) bus ();

  div_rr_scheduler #(.N_REQ(N), .DW(DW), .TMO_CYC(TMO)) dut (
    .clk        (clk),
    .sclr_n     (sclr_n),
    .bus        (bus),
    .sched_busy (sched_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;
  logic [DW-1:0] op_a [N];
  logic [DW-1:0] op_b [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: first requester after the last served one, wrapping.
  function automatic int rr_expect(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic drive_operands();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DW +: DW] = op_a[i];
      bus.req_b[i*DW +: DW] = op_b[i];
    end
  endtask

  task automatic randomize_operands(input bit allow_zero);
    for (int i = 0; i < N; i++) begin
      op_a[i] = DW'($urandom);
      op_b[i] = (allow_zero && $urandom_range(0, 5) == 0) ? '0 : DW'($urandom_range(1, 1023));
    end
    drive_operands();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    32'(bus.gnt), 0);
    check({tag, "_done"},   32'(bus.done), 0);
    check({tag, "_start"},  32'(bus.div_start), 0);
    check({tag, "_a"},      32'(bus.div_a), 0);
    check({tag, "_b"},      32'(bus.div_b), 0);
    check({tag, "_q"},      32'(bus.rsp_q), 0);
    check({tag, "_status"}, 32'(bus.rsp_status), 0);
    check({tag, "_busy"},   32'(sched_busy), 0);
    check({tag, "_sclr"},   32'(bus.div_sclr), 1);
  endtask

  task automatic do_reset();
    sclr_n        = 1'b0;
    bus.req       = '0;
    bus.div_valid = 1'b0;
    bus.div_ovf   = 1'b0;
    bus.div_dvz   = 1'b0;
    bus.div_q     = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    sclr_n    = 1'b1;
    model_ptr = N - 1;
    @(negedge clk);
    check("reset_release_sclr", 32'(bus.div_sclr), 0);
  endtask

  // One full transaction: request, grant, start, divider reply, done.
  task automatic do_op(input logic [N-1:0] r, input logic [N-1:0] r_after,
                       input int mode, input int lat);
    int w;
    int n;
    logic [DW-1:0] g;
    logic [DW-1:0] exp_q;
    status_t exp_st;
    bus.req = r;
    w = rr_expect(r, model_ptr);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 20);
    check("gnt_wait", 32'(n), 1);
    check("gnt", 32'(bus.gnt), 32'(N'(1) << w));
    check("div_a", 32'(bus.div_a), 32'(op_a[w]));
    check("div_b", 32'(bus.div_b), 32'(op_b[w]));
    check("busy_gnt", 32'(sched_busy), 1);
    @(negedge clk);
    bus.req = r_after;
    check("start", 32'(bus.div_start), 1);
    check("gnt_pulse", 32'(bus.gnt), 0);
    @(negedge clk);
    check("start_pulse", 32'(bus.div_start), 0);
    repeat (lat) @(negedge clk);
    g = DW'($urandom_range(1, 1023));
    if (mode == M_NEVER) begin
      n = 0;
      while (bus.div_sclr !== 1'b1 && n < 3 * TMO) begin
        @(negedge clk);
        n++;
      end
      check("tmo_delay", 32'(n), TMO - 2);
      check("tmo_no_done_yet", 32'(bus.done), 0);
      exp_q  = '0;
      exp_st = ST_TMO;
      @(negedge clk);
    end else begin
      case (mode)
        M_OVF: begin
          bus.div_ovf = 1'b1;
          bus.div_q   = g;
          exp_q  = g;
          exp_st = ST_OVF;
        end
        M_BOTH: begin
          bus.div_ovf = 1'b1;
          bus.div_dvz = 1'b1;
          bus.div_q   = g;
          exp_q  = '0;
          exp_st = ST_DVZ;
        end
        default: begin
          if (op_b[w] == '0) begin
            bus.div_dvz = 1'b1;
            bus.div_q   = g;
            exp_q  = '0;
            exp_st = ST_DVZ;
          end else begin
            bus.div_valid = 1'b1;
            bus.div_q     = op_a[w] / op_b[w];
            exp_q  = op_a[w] / op_b[w];
            exp_st = ST_OK;
          end
        end
      endcase
      @(negedge clk);
      bus.div_valid = 1'b0;
      bus.div_ovf   = 1'b0;
      bus.div_dvz   = 1'b0;
      check("sclr_quiet", 32'(bus.div_sclr), 0);
    end
    check("done", 32'(bus.done), 32'(N'(1) << w));
    check("rsp_q", 32'(bus.rsp_q), 32'(exp_q));
    check("rsp_status", 32'(bus.rsp_status), 32'(exp_st));
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 0);
    check("idle_busy", 32'(sched_busy), 0);
    model_ptr = w;
  endtask

  initial begin
    int n;
    int bad;
    logic [N-1:0] r;
    int mode;
    bus.req_a = '0;
    bus.req_b = '0;
    do_reset();

    // Single requester.
    op_a[0] = 10'd100;
    op_b[0] = 10'd7;
    drive_operands();
    do_op(4'b0001, 4'b0000, M_AUTO, 2);

    // Fairness with all requesters held.
    randomize_operands(1'b0);
    for (int i = 0; i < 8; i++) do_op(4'b1111, 4'b1111, M_AUTO, int'($urandom_range(0, 4)));

    // Error statuses.
    op_b[1] = '0;
    drive_operands();
    do_op(4'b0010, 4'b0000, M_AUTO, 1);
    do_op(4'b0100, 4'b0000, M_OVF, 3);
    do_op(4'b1000, 4'b0000, M_BOTH, 0);

    // Dropped req[0] after grant, req[1] raised during WAIT.
    randomize_operands(1'b0);
    do_op(4'b0001, 4'b0010, M_AUTO, 3);
    do_op(4'b0010, 4'b0000, M_AUTO, 1);

    // Completion pulse while idle is ignored.
    bus.req       = '0;
    bus.div_valid = 1'b1;
    @(negedge clk);
    bus.div_valid = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done != '0 || sched_busy) bad++;
    end
    check("idle_cpl_ignored", 32'(bad), 0);

    // Mid-operation reset.
    bus.req = 4'b0011;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 20);
    check("rst_gnt_seen", 32'(bus.gnt != '0), 1);
    repeat (3) @(negedge clk);
    sclr_n  = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check_all_zero("midrst");
    sclr_n    = 1'b1;
    model_ptr = N - 1;
    bus.div_valid = 1'b1;
    @(negedge clk);
    bus.div_valid = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done != '0) bad++;
    end
    check("midrst_no_done", 32'(bad), 0);
    do_op(4'b0100, 4'b0000, M_AUTO, 1);
    do_op(4'b0101, 4'b0000, M_AUTO, 1);

`ifdef DIV_SCHED_TIMEOUT_EN
    do_op(4'b0010, 4'b0000, M_NEVER, 0);
`else
    bus.req = 4'b0010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 20);
    bus.req = '0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!sched_busy || bus.done != '0 || bus.div_sclr) bad++;
    end
    check("wait_unbounded", 32'(bad), 0);
    do_reset();
`endif

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      randomize_operands(1'b1);
      r = N'($urandom_range(1, 15));
      n = int'($urandom_range(0, 9));
      mode = (n < 6) ? M_AUTO : (n < 8) ? M_OVF : M_BOTH;
      do_op(r, N'($urandom_range(0, 15)), mode, int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
